// File: rtl/alu_issue_ctrl.sv
// ============================================================================
// alu_issue_ctrl : issues one request at a time to the ALU and returns its result
// Optional: ALU_ISSUE_STATS_EN adds saturating op/err counters. Rev 1.0
// ============================================================================
`default_nettype none

`ifndef ARITH_LOGIC
`define ARITH_LOGIC 3'b001
`endif

module alu_issue_ctrl #(
  parameter int          TAG_W     = 4,
  parameter logic [2:0]  ARITH_SEL = `ARITH_LOGIC
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_op1,
  input  logic [31:0]       req_op2,
  input  logic [2:0]        req_opselect,
  input  logic [2:0]        req_operation,
  input  logic [TAG_W-1:0]  req_tag,
  output logic [31:0]       aluin1,
  output logic [31:0]       aluin2,
  output logic [2:0]        aluopselect,
  output logic [2:0]        aluoperation,
  output logic              alu_enable,
  input  logic [31:0]       aluout,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_data,
  output logic [TAG_W-1:0]  rsp_tag,
`ifdef ALU_ISSUE_STATS_EN
  output logic [15:0]       op_count,
  output logic [15:0]       err_count,
`endif
  output logic              rsp_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    CAPT = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next;

  logic [31:0]       r_aluin1;
  logic [31:0]       r_aluin2;
  logic [2:0]        r_aluopselect;
  logic [2:0]        r_aluoperation;
  logic              r_alu_enable;
  logic [TAG_W-1:0]  r_tag;
  logic              r_rsp_valid;
  logic [31:0]       r_rsp_data;
  logic [TAG_W-1:0]  r_rsp_tag;
  logic              r_rsp_err;

  logic              w_req_hs;
  logic              w_accept;
  logic              w_reject;
  logic              w_rsp_hs;

  assign w_req_hs = (r_state == IDLE) && req_valid;
  assign w_accept = w_req_hs && (req_opselect == ARITH_SEL);
  assign w_reject = w_req_hs && (req_opselect != ARITH_SEL);
  assign w_rsp_hs = (r_state == RESP) && rsp_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_next = EXEC;
        end else if (w_reject) begin
          w_next = RESP;
        end
      end
      EXEC:    w_next = CAPT;
      CAPT:    w_next = RESP;
      RESP: begin
        if (rsp_ready) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Operand registers hold their last value between operations; only the enable pulses.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_aluin1       <= '0;
      r_aluin2       <= '0;
      r_aluopselect  <= '0;
      r_aluoperation <= '0;
      r_alu_enable   <= 1'b0;
      r_tag          <= '0;
      r_rsp_valid    <= 1'b0;
      r_rsp_data     <= '0;
      r_rsp_tag      <= '0;
      r_rsp_err      <= 1'b0;
    end else begin
      r_alu_enable <= w_accept;
      if (w_accept) begin
        r_aluin1       <= req_op1;
        r_aluin2       <= req_op2;
        r_aluopselect  <= req_opselect;
        r_aluoperation <= req_operation;
        r_tag          <= req_tag;
      end
      if (w_reject) begin
        r_rsp_valid <= 1'b1;
        r_rsp_err   <= 1'b1;
        r_rsp_data  <= '0;
        r_rsp_tag   <= req_tag;
      end else if (r_state == CAPT) begin
        r_rsp_valid <= 1'b1;
        r_rsp_err   <= 1'b0;
        r_rsp_data  <= aluout;
        r_rsp_tag   <= r_tag;
      end else if (w_rsp_hs) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

`ifdef ALU_ISSUE_STATS_EN
  logic [15:0] r_op_count;
  logic [15:0] r_err_count;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_op_count  <= '0;
      r_err_count <= '0;
    end else if (w_rsp_hs) begin
      if (!r_rsp_err && (r_op_count != 16'hFFFF)) begin
        r_op_count <= r_op_count + 16'd1;
      end
      if (r_rsp_err && (r_err_count != 16'hFFFF)) begin
        r_err_count <= r_err_count + 16'd1;
      end
    end
  end

  assign op_count  = r_op_count;
  assign err_count = r_err_count;
`endif

  assign req_ready    = (r_state == IDLE);
  assign aluin1       = r_aluin1;
  assign aluin2       = r_aluin2;
  assign aluopselect  = r_aluopselect;
  assign aluoperation = r_aluoperation;
  assign alu_enable   = r_alu_enable;
  assign rsp_valid    = r_rsp_valid;
  assign rsp_data     = r_rsp_data;
  assign rsp_tag      = r_rsp_tag;
  assign rsp_err      = r_rsp_err;

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
// ============================================================================
// tb_alu_issue_ctrl : directed + random checks of alu_issue_ctrl against a
// request-level model with a registered ALU stub. Rev 1.0
// ============================================================================
`default_nettype none

`ifndef ARITH_LOGIC
`define ARITH_LOGIC 3'b001
`endif

module tb_alu_issue_ctrl;

  localparam int         TAG_W     = 4;
  localparam logic [2:0] ARITH_SEL = `ARITH_LOGIC;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_HADD = 3'd1;
  localparam logic [2:0] OP_SUB  = 3'd2;
  localparam logic [2:0] OP_NOT  = 3'd3;
  localparam logic [2:0] OP_AND  = 3'd4;
  localparam logic [2:0] OP_OR   = 3'd5;
  localparam logic [2:0] OP_XOR  = 3'd6;
  localparam logic [2:0] OP_LHG  = 3'd7;

  logic              clock = 1'b0;
  logic              reset;
  logic              req_valid;
  logic              req_ready;
  logic [31:0]       req_op1;
  logic [31:0]       req_op2;
  logic [2:0]        req_opselect;
  logic [2:0]        req_operation;
  logic [TAG_W-1:0]  req_tag;
  logic [31:0]       aluin1;
  logic [31:0]       aluin2;
  logic [2:0]        aluopselect;
  logic [2:0]        aluoperation;
  logic              alu_enable;
  logic [31:0]       aluout = 32'd0;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_data;
  logic [TAG_W-1:0]  rsp_tag;
  logic              rsp_err;
`ifdef ALU_ISSUE_STATS_EN
  logic [15:0]       op_count;
  logic [15:0]       err_count;
`endif

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [31:0] last_a;
  logic [31:0] last_b;
  logic [2:0]  last_sel;
  logic [2:0]  last_op;
  logic [31:0] seen_data;
  int unsigned exp_ops;
  int unsigned exp_errs;

  alu_issue_ctrl #(.TAG_W(TAG_W), .ARITH_SEL(ARITH_SEL)) dut (
    .clock         (clock),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_op1       (req_op1),
    .req_op2       (req_op2),
    .req_opselect  (req_opselect),
    .req_operation (req_operation),
    .req_tag       (req_tag),
    .aluin1        (aluin1),
    .aluin2        (aluin2),
    .aluopselect   (aluopselect),
    .aluoperation  (aluoperation),
    .alu_enable    (alu_enable),
    .aluout        (aluout),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_data      (rsp_data),
    .rsp_tag       (rsp_tag),
`ifdef ALU_ISSUE_STATS_EN
    .op_count      (op_count),
    .err_count     (err_count),
`endif
    .rsp_err       (rsp_err)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] alu_fn(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    logic [15:0] h;
    h = a[15:0] + b[15:0];
    case (op)
      OP_ADD:  return a + b;
      OP_HADD: return {{16{h[15]}}, h};
      OP_SUB:  return a - b;
      OP_NOT:  return ~a;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      default: return {b[15:0], 16'h0000};
    endcase
  endfunction

  // Registered ALU stand-in: result appears the cycle after enable.
  always @(posedge clock) begin
    if (alu_enable) aluout <= alu_fn(aluoperation, aluin1, aluin2);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive_junk();
    req_valid     = 1'b1;
    req_op1       = $urandom;
    req_op2       = $urandom;
    req_opselect  = 3'($urandom_range(0, 7));
    req_operation = 3'($urandom_range(0, 7));
    req_tag       = TAG_W'($urandom_range(0, 15));
  endtask

  task automatic run_req(input logic [31:0] a, input logic [31:0] b, input logic [2:0] sel,
                         input logic [2:0] op, input logic [TAG_W-1:0] tag, input int stall);
    bit          acc;
    logic [31:0] ed;
    acc = (sel == ARITH_SEL);
    ed  = acc ? alu_fn(op, a, b) : 32'd0;
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_op1 = a; req_op2 = b;
    req_opselect = sel; req_operation = op; req_tag = tag;
    rsp_ready = (stall == 0);
    @(negedge clock);
    drive_junk();
    if (acc) begin
      chk("en_exec", 32'(alu_enable), 32'd1);
      chk("aluin1", aluin1, a);
      chk("aluin2", aluin2, b);
      chk("aluopselect", 32'(aluopselect), 32'(sel));
      chk("aluoperation", 32'(aluoperation), 32'(op));
      chk("rsp_valid_exec", 32'(rsp_valid), 32'd0);
      chk("req_ready_exec", 32'(req_ready), 32'd0);
      @(negedge clock);
      drive_junk();
      chk("en_capt", 32'(alu_enable), 32'd0);
      chk("rsp_valid_capt", 32'(rsp_valid), 32'd0);
      chk("aluin1_capt", aluin1, a);
      @(negedge clock);
      last_a = a; last_b = b; last_sel = sel; last_op = op;
    end else begin
      chk("en_reject", 32'(alu_enable), 32'd0);
      chk("aluin1_hold", aluin1, last_a);
      chk("aluin2_hold", aluin2, last_b);
      chk("aluopselect_hold", 32'(aluopselect), 32'(last_sel));
      chk("aluoperation_hold", 32'(aluoperation), 32'(last_op));
    end
    chk("rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rsp_data", rsp_data, ed);
    chk("rsp_tag", 32'(rsp_tag), 32'(tag));
    chk("rsp_err", 32'(rsp_err), acc ? 32'd0 : 32'd1);
    chk("req_ready_resp", 32'(req_ready), 32'd0);
    seen_data = rsp_data;
    if (stall == 0) req_valid = 1'b0;
    for (int i = 0; i < stall; i++) begin
      drive_junk();
      @(negedge clock);
      chk("stall_valid", 32'(rsp_valid), 32'd1);
      chk("stall_data", rsp_data, ed);
      chk("stall_tag", 32'(rsp_tag), 32'(tag));
      chk("stall_req_ready", 32'(req_ready), 32'd0);
      chk("stall_en", 32'(alu_enable), 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clock);
    chk("rsp_valid_done", 32'(rsp_valid), 32'd0);
    chk("req_ready_done", 32'(req_ready), 32'd1);
    chk("en_done", 32'(alu_enable), 32'd0);
    if (acc) begin
      if (exp_ops < 32'hFFFF) exp_ops++;
    end else begin
      if (exp_errs < 32'hFFFF) exp_errs++;
    end
    rsp_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_en"},     32'(alu_enable), 32'd0);
    chk({tag, "_aluin1"}, aluin1, 32'd0);
    chk({tag, "_aluin2"}, aluin2, 32'd0);
    chk({tag, "_sel"},    32'(aluopselect), 32'd0);
    chk({tag, "_op"},     32'(aluoperation), 32'd0);
    chk({tag, "_rvalid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rdata"},  rsp_data, 32'd0);
    chk({tag, "_rtag"},   32'(rsp_tag), 32'd0);
    chk({tag, "_rerr"},   32'(rsp_err), 32'd0);
    chk({tag, "_ready"},  32'(req_ready), 32'd1);
  endtask

  initial begin
    logic [2:0] bad_sel;
    bad_sel = ~ARITH_SEL;
    reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    req_op1 = '0; req_op2 = '0; req_opselect = '0; req_operation = '0; req_tag = '0;
    last_a = '0; last_b = '0; last_sel = '0; last_op = '0;
    exp_ops = 0; exp_errs = 0;
    repeat (3) @(negedge clock);
    chk_all_zero("reset");
    reset = 1'b0;
    @(negedge clock);

    run_req(32'd5, 32'd7, ARITH_SEL, OP_ADD, 4'd3, 0);
    chk("add_5_7", seen_data, 32'd12);
    run_req(32'd5, 32'd7, ARITH_SEL, OP_SUB, 4'd1, 0);
    chk("sub_5_7", seen_data, 32'hFFFF_FFFE);
    run_req(32'h0001_FFFF, 32'h0002_0001, ARITH_SEL, OP_HADD, 4'd2, 0);
    chk("hadd_wrap", seen_data, 32'h0000_0000);
    run_req(32'h1234_5678, 32'h9ABC_DEF0, bad_sel, OP_ADD, 4'd9, 0);
    chk("reject_data", seen_data, 32'd0);
    run_req(32'd100, 32'd23, ARITH_SEL, OP_ADD, 4'd6, 5);
    chk("hold_add", seen_data, 32'd123);

    for (int n = 0; n < 24; n++) begin
      run_req($urandom, $urandom,
              ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : ARITH_SEL,
              3'($urandom_range(0, 7)), TAG_W'($urandom_range(0, 15)),
              int'($urandom_range(0, 3)));
    end

    // Abort a request in EXEC: it must vanish without a response.
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_op1 = 32'hDEAD_BEEF; req_op2 = 32'h1;
    req_opselect = ARITH_SEL; req_operation = OP_ADD; req_tag = 4'd5;
    @(negedge clock);
    req_valid = 1'b0;
    chk("abort_in_exec", 32'(alu_enable), 32'd1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk_all_zero("abort");
    last_a = '0; last_b = '0; last_sel = '0; last_op = '0;
    exp_ops = 0; exp_errs = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("abort_no_rsp", 32'(rsp_valid), 32'd0);
      chk("abort_no_en", 32'(alu_enable), 32'd0);
    end

`ifdef ALU_ISSUE_STATS_EN
    chk("op_count_reset", 32'(op_count), 32'd0);
    run_req(32'd1, 32'd2, ARITH_SEL, OP_ADD, 4'd1, 0);
    run_req(32'd3, 32'd4, bad_sel, OP_AND, 4'd2, 1);
    run_req(32'd5, 32'd6, ARITH_SEL, OP_OR, 4'd3, 0);
    run_req(32'd7, 32'd8, bad_sel, OP_XOR, 4'd4, 0);
    run_req(32'd9, 32'd1, ARITH_SEL, OP_SUB, 4'd5, 2);
    chk("op_count", 32'(op_count), exp_ops);
    chk("err_count", 32'(err_count), exp_errs);
    chk("op_count_3", 32'(op_count), 32'd3);
    chk("err_count_2", 32'(err_count), 32'd2);
    force dut.r_op_count = 16'hFFFF;
    @(negedge clock);
    release dut.r_op_count;
    run_req(32'd1, 32'd1, ARITH_SEL, OP_ADD, 4'd7, 0);
    chk("op_count_sat", 32'(op_count), 32'h0000_FFFF);
    chk("err_count_after_sat", 32'(err_count), 32'd2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
